// File: rtl/rf_access_arbiter.sv
// -----------------------------------------------------------------------------
// rf_access_arbiter
//
// Purpose:
//   Sits in front of a register file with one read/write port (X), one
//   read-only port (Y) and asynchronous reads. Two requesters, A (CPU control)
//   and B (debug/monitor), share the register file. One transaction is
//   performed per cycle with round-robin fairness. A built-in clear sequencer
//   walks every register and writes 0.
//
// Optional feature (macro RF_ARB_LOCK_EN):
//   When defined, A_LOCK/B_LOCK inputs are added. A requester that was granted
//   last and holds REQ+LOCK keeps the grant, even under contention. This gives
//   back-to-back read-modify-write sequences.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   A_REQ/A_WE               requester A request and write enable
//   A_ADRX/A_ADRY/A_DIN      requester A X address, Y address and write data
//   A_ACK                    A transaction performed this cycle
//   A_DX/A_DY                A registered X/Y read data (valid after ACK)
//   B_*                      same as A_* for requester B
//   A_LOCK/B_LOCK            grant lock (only with RF_ARB_LOCK_EN)
//   CLR_START                pulse to start clearing all registers
//   CLR_BUSY/CLR_DONE        clear in progress / one-cycle completion pulse
//   RF_DIN/RF_ADRX/RF_ADRY   register file data and address inputs
//   RF_WR                    register file write enable
//   RF_DX/RF_DY              register file asynchronous read data
// -----------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADRX,
  input  logic [ADDR_W-1:0] A_ADRY,
  input  logic [DATA_W-1:0] A_DIN,
  output logic              A_ACK,
  output logic [DATA_W-1:0] A_DX,
  output logic [DATA_W-1:0] A_DY,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADRX,
  input  logic [ADDR_W-1:0] B_ADRY,
  input  logic [DATA_W-1:0] B_DIN,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_DX,
  output logic [DATA_W-1:0] B_DY,
`ifdef RF_ARB_LOCK_EN
  input  logic              A_LOCK,
  input  logic              B_LOCK,
`endif
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic [DATA_W-1:0] RF_DIN,
  output logic [ADDR_W-1:0] RF_ADRX,
  output logic [ADDR_W-1:0] RF_ADRY,
  output logic              RF_WR,
  input  logic [DATA_W-1:0] RF_DX,
  input  logic [DATA_W-1:0] RF_DY
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_last_b;     // 1: B holds last_grant, 0: A holds it
  logic                r_clr_done;
  logic [DATA_W-1:0]   r_a_dx, r_a_dy, r_b_dx, r_b_dy;
  logic                w_a_lock, w_b_lock;
  logic                w_a_win, w_b_win;

`ifdef RF_ARB_LOCK_EN
  assign w_a_lock = A_LOCK;
  assign w_b_lock = B_LOCK;
`else
  assign w_a_lock = 1'b0;
  assign w_b_lock = 1'b0;
`endif

  // Round-robin: under contention the requester that was not granted last
  // wins, unless the last-granted requester holds its lock.
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    if (A_REQ && B_REQ) begin
      if (r_last_b) begin
        w_b_win = w_b_lock;
        w_a_win = !w_b_lock;
      end else begin
        w_a_win = w_a_lock;
        w_b_win = !w_a_lock;
      end
    end else begin
      w_a_win = A_REQ;
      w_b_win = B_REQ;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    RF_DIN      = '0;
    RF_ADRX     = '0;
    RF_ADRY     = '0;
    RF_WR       = 1'b0;
    A_ACK       = 1'b0;
    B_ACK       = 1'b0;
    CLR_BUSY    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CLR_START) begin
          // Clear request beats pending transactions; nothing is acked.
          w_state_nxt = S_CLEAR;
        end else if (w_a_win) begin
          RF_ADRX = A_ADRX;
          RF_ADRY = A_ADRY;
          RF_DIN  = A_DIN;
          RF_WR   = A_WE;
          A_ACK   = 1'b1;
        end else if (w_b_win) begin
          RF_ADRX = B_ADRX;
          RF_ADRY = B_ADRY;
          RF_DIN  = B_DIN;
          RF_WR   = B_WE;
          B_ACK   = 1'b1;
        end
      end
      S_CLEAR: begin
        CLR_BUSY  = 1'b1;
        RF_WR     = 1'b1;
        RF_ADRX   = r_cnt;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset wins: no ack and no register file write in a reset cycle, so an
    // aborted clear leaves the current counter address untouched.
    if (RST) begin
      A_ACK = 1'b0;
      B_ACK = 1'b0;
      RF_WR = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_b   <= 1'b1;
      r_clr_done <= 1'b0;
      r_a_dx     <= '0;
      r_a_dy     <= '0;
      r_b_dx     <= '0;
      r_b_dy     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_done <= (r_state == S_CLEAR) && (r_cnt == CNT_LAST);
      // Read data is captured on every ack, writes included (pre-write value).
      if (A_ACK) begin
        r_last_b <= 1'b0;
        r_a_dx   <= RF_DX;
        r_a_dy   <= RF_DY;
      end else if (B_ACK) begin
        r_last_b <= 1'b1;
        r_b_dx   <= RF_DX;
        r_b_dy   <= RF_DY;
      end
    end
  end

  assign A_DX     = r_a_dx;
  assign A_DY     = r_a_dy;
  assign B_DX     = r_b_dx;
  assign B_DY     = r_b_dy;
  assign CLR_DONE = r_clr_done;

endmodule

// File: tb/tb_rf_access_arbiter.sv
module tb_rf_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       A_REQ, A_WE, B_REQ, B_WE;
  logic [4:0] A_ADRX, A_ADRY, B_ADRX, B_ADRY;
  logic [7:0] A_DIN, B_DIN;
  logic       A_ACK, B_ACK;
  logic [7:0] A_DX, A_DY, B_DX, B_DY;
  logic       A_LOCK, B_LOCK;
  logic       CLR_START, CLR_BUSY, CLR_DONE;
  logic [7:0] RF_DIN;
  logic [4:0] RF_ADRX, RF_ADRY;
  logic       RF_WR;
  logic [7:0] RF_DX, RF_DY;

  logic       tb_init;
  logic [7:0] mem [32];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  rf_access_arbiter #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADRX(A_ADRX), .A_ADRY(A_ADRY), .A_DIN(A_DIN),
    .A_ACK(A_ACK), .A_DX(A_DX), .A_DY(A_DY),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADRX(B_ADRX), .B_ADRY(B_ADRY), .B_DIN(B_DIN),
    .B_ACK(B_ACK), .B_DX(B_DX), .B_DY(B_DY),
`ifdef RF_ARB_LOCK_EN
    .A_LOCK(A_LOCK), .B_LOCK(B_LOCK),
`endif
    .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .RF_DIN(RF_DIN), .RF_ADRX(RF_ADRX), .RF_ADRY(RF_ADRY), .RF_WR(RF_WR),
    .RF_DX(RF_DX), .RF_DY(RF_DY)
  );

  // Register file model: asynchronous reads, write on rising edge.
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (RF_WR) begin
      mem[RF_ADRX] <= RF_DIN;
    end
  end
  assign RF_DX = mem[RF_ADRX];
  assign RF_DY = mem[RF_ADRY];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are changed right after a falling edge; checks follow 1 ns later.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic fill_a5();
    int acks;
    acks = 0;
    for (int i = 0; i < 32; i++) begin
      A_REQ = 1'b1; A_WE = 1'b1; A_ADRX = 5'(i); A_ADRY = 5'd0; A_DIN = 8'hA5;
      settle();
      if (A_ACK) acks++;
      tick();
    end
    A_REQ = 1'b0; A_WE = 1'b0;
    check_val("fill_acks", 32'(acks), 32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad_lo, bad_hi;
    RST = 1'b1; tb_init = 1'b1;
    A_REQ = 1'b1; A_WE = 1'b0; A_ADRX = '0; A_ADRY = '0; A_DIN = '0;
    B_REQ = 1'b0; B_WE = 1'b0; B_ADRX = '0; B_ADRY = '0; B_DIN = '0;
    A_LOCK = 1'b0; B_LOCK = 1'b0; CLR_START = 1'b0;

    // Reset: a request during reset must not be acked.
    tick();
    settle();
    check_val("rst_no_ack", 32'(A_ACK), 0);
    check_val("rst_no_wr", 32'(RF_WR), 0);
    tick();
    RST = 1'b0; tb_init = 1'b0; A_REQ = 1'b0;
    settle();
    check_val("rst_a_dx", 32'(A_DX), 0);
    check_val("rst_b_dy", 32'(B_DY), 0);
    check_val("rst_busy", 32'(CLR_BUSY), 0);
    check_val("rst_done", 32'(CLR_DONE), 0);
    check_val("idle_adrx", 32'(RF_ADRX), 0);

    // A writes reg 3 = 0x5A, then reads it back on X and Y.
    A_REQ = 1'b1; A_WE = 1'b1; A_ADRX = 5'd3; A_DIN = 8'h5A;
    settle();
    check_val("t1_wr_ack", 32'(A_ACK), 1);
    check_val("t1_wr_back", 32'(B_ACK), 0);
    check_val("t1_wr_rfwr", 32'(RF_WR), 1);
    check_val("t1_wr_adrx", 32'(RF_ADRX), 3);
    check_val("t1_wr_din", 32'(RF_DIN), 32'h5A);
    tick();
    A_WE = 1'b0; A_ADRY = 5'd3; A_DIN = 8'h00;
    settle();
    check_val("t1_rd_ack", 32'(A_ACK), 1);
    check_val("t1_rd_rfwr", 32'(RF_WR), 0);
    check_val("t1_prewrite_dx", 32'(A_DX), 3);
    tick();
    A_REQ = 1'b0;
    settle();
    check_val("t1_dx", 32'(A_DX), 32'h5A);
    check_val("t1_dy", 32'(A_DY), 32'h5A);
    check_val("t1_idle_ack", 32'(A_ACK), 0);
    check_val("t1_idle_wr", 32'(RF_WR), 0);

    // Contention from reset: A, B, A, B.
    pulse_reset();
    settle();
    check_val("t2_rst_clears_dx", 32'(A_DX), 0);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADRX = 5'd1; A_ADRY = 5'd2;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADRX = 5'd4; B_ADRY = 5'd5;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_val("t2_a_ack", 32'(A_ACK), (k % 2 == 0) ? 1 : 0);
      check_val("t2_b_ack", 32'(B_ACK), (k % 2 == 1) ? 1 : 0);
      check_val("t2_adrx", 32'(RF_ADRX), (k % 2 == 0) ? 1 : 4);
      check_val("t2_adry", 32'(RF_ADRY), (k % 2 == 0) ? 2 : 5);
      tick();
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    settle();
    check_val("t2_a_dx", 32'(A_DX), 1);
    check_val("t2_a_dy", 32'(A_DY), 2);
    check_val("t2_b_dx", 32'(B_DX), 4);
    check_val("t2_b_dy", 32'(B_DY), 5);

    // B alone writes reg 7 = 0xFF every cycle.
    B_REQ = 1'b1; B_WE = 1'b1; B_ADRX = 5'd7; B_ADRY = 5'd0; B_DIN = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_val("t3_b_ack", 32'(B_ACK), 1);
      check_val("t3_a_ack", 32'(A_ACK), 0);
      check_val("t3_rfwr", 32'(RF_WR), 1);
      tick();
    end
    B_REQ = 1'b0; B_WE = 1'b0;
    settle();
    check_val("t3_idle_wr", 32'(RF_WR), 0);
    check_val("t3_b_dx", 32'(B_DX), 32'hFF);
    check_val("t3_a_dx_held", 32'(A_DX), 1);
    check_val("t3_mem7", 32'(mem[7]), 32'hFF);

    // Full clear with A request pending; a second CLR_START mid-clear is ignored.
    fill_a5();
    A_REQ = 1'b1; A_WE = 1'b0; A_ADRX = 5'd9; A_ADRY = 5'd10;
    CLR_START = 1'b1;
    settle();
    check_val("t4_start_no_ack", 32'(A_ACK), 0);
    check_val("t4_start_no_wr", 32'(RF_WR), 0);
    tick();
    CLR_START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) CLR_START = 1'b1;
      if (i == 6) CLR_START = 1'b0;
      settle();
      check_val("t4_busy", 32'(CLR_BUSY), 1);
      check_val("t4_no_ack", 32'(A_ACK), 0);
      check_val("t4_wr", 32'(RF_WR), 1);
      check_val("t4_adrx", 32'(RF_ADRX), 32'(i));
      check_val("t4_din", 32'(RF_DIN), 0);
      check_val("t4_done_low", 32'(CLR_DONE), 0);
      tick();
    end
    settle();
    check_val("t4_done", 32'(CLR_DONE), 1);
    check_val("t4_busy_low", 32'(CLR_BUSY), 0);
    check_val("t4_ack_on_done", 32'(A_ACK), 1);
    check_val("t4_ack_adrx", 32'(RF_ADRX), 9);
    tick();
    A_REQ = 1'b0;
    settle();
    check_val("t4_done_pulse", 32'(CLR_DONE), 0);
    check_val("t4_a_dx", 32'(A_DX), 0);
    check_val("t4_a_dy", 32'(A_DY), 0);
    bad_lo = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 8'h00) bad_lo++;
    check_val("t4_regs_nonzero", 32'(bad_lo), 0);

    // Reset aborts a clear at counter 10.
    fill_a5();
    CLR_START = 1'b1;
    tick();
    CLR_START = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b1;
    settle();
    check_val("t5_busy_at10", 32'(CLR_BUSY), 1);
    check_val("t5_adrx_at10", 32'(RF_ADRX), 10);
    check_val("t5_rst_no_wr", 32'(RF_WR), 0);
    tick();
    RST = 1'b0;
    settle();
    check_val("t5_busy_low", 32'(CLR_BUSY), 0);
    check_val("t5_no_done", 32'(CLR_DONE), 0);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADRX = 5'd10; A_ADRY = 5'd9;
    tick();
    A_REQ = 1'b0;
    settle();
    check_val("t5_no_done2", 32'(CLR_DONE), 0);
    check_val("t5_a_dx_reg10", 32'(A_DX), 32'hA5);
    check_val("t5_a_dy_reg9", 32'(A_DY), 0);
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 10; i++) if (mem[i] != 8'h00) bad_lo++;
    for (int i = 10; i < 32; i++) if (mem[i] != 8'hA5) bad_hi++;
    check_val("t5_low_regs_bad", 32'(bad_lo), 0);
    check_val("t5_high_regs_bad", 32'(bad_hi), 0);

`ifdef RF_ARB_LOCK_EN
    // Locked A keeps the grant under contention; dropping the lock hands to B.
    pulse_reset();
    A_REQ = 1'b1; A_WE = 1'b0; A_ADRX = 5'd1; A_LOCK = 1'b1;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADRX = 5'd2;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_val("t6_lock_a_ack", 32'(A_ACK), 1);
      check_val("t6_lock_b_ack", 32'(B_ACK), 0);
      tick();
    end
    A_LOCK = 1'b0;
    settle();
    check_val("t6_unlock_b_ack", 32'(B_ACK), 1);
    check_val("t6_unlock_a_ack", 32'(A_ACK), 0);
    tick();
    settle();
    check_val("t6_rr_a_ack", 32'(A_ACK), 1);
    tick();
    A_REQ = 1'b0; B_REQ = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
Shares the single register file between two requesters: A (CPU control unit) and B (debug/monitor port). The register file has one read/write address X, one read-only address Y, and asynchronous reads. The block performs one transaction per cycle with round-robin fairness. It also contains a clear sequencer that walks every register and writes 0. It sits directly in front of the register file and drives all of its address, data and write-enable inputs.

Parameters:
DATA_W, 8, register data width
ADDR_W, 5, register address width; the register count is 2**ADDR_W (32)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
A_REQ  in  1  requester A transaction request
A_WE  in  1  A write (1) or read (0)
A_ADRX  in  ADDR_W  A X address (write or read)
A_ADRY  in  ADDR_W  A Y address (read only)
A_DIN  in  DATA_W  A write data
A_ACK  out  1  A transaction performed this cycle
A_DX  out  DATA_W  A registered X read data
A_DY  out  DATA_W  A registered Y read data
B_REQ, B_WE, B_ADRX, B_ADRY, B_DIN, B_ACK, B_DX, B_DY  same directions, widths and meanings as the A ports, for requester B
CLR_START  in  1  pulse: start clearing all registers
CLR_BUSY  out  1  clear in progress
CLR_DONE  out  1  one-cycle pulse when the clear finishes
RF_DIN  out  DATA_W  to register file DIN
RF_ADRX  out  ADDR_W  to register file ADRX
RF_ADRY  out  ADDR_W  to register file ADRY
RF_WR  out  1  to register file RF_WR
RF_DX  in  DATA_W  from register file DX_OUT
RF_DY  in  DATA_W  from register file DY_OUT

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset values: state IDLE, clear counter 0, last_grant = B (so A wins the first contention), A_DX/A_DY/B_DX/B_DY = 0, CLR_BUSY = 0, CLR_DONE = 0.
- The FSM has two states: IDLE and CLEAR.
- IDLE, arbitration (combinational on the current REQs):
  - Only one requester asserts REQ: that requester wins.
  - Both assert REQ: the requester that is not last_grant wins.
  - Neither asserts REQ: no transaction.
- IDLE, winner cycle:
  - RF_ADRX/RF_ADRY/RF_DIN = the winner's fields; RF_WR = the winner's WE.
  - The winner's ACK = 1 in the same cycle. The loser's ACK = 0.
  - last_grant updates to the winner at the clock edge.
- IDLE, no transaction: RF_WR = 0, RF_ADRX/RF_ADRY/RF_DIN = 0, both ACKs = 0.
- Read latency: on the ACK cycle, the winner's DX/DY register RF_DX/RF_DY at the clock edge. Data is valid the cycle after ACK and holds until that requester's next ACK.
  - On a write ACK, DX/DY still capture RF_DX/RF_DY, which is the pre-write value at the X address.
- Requester obligations: hold REQ and all fields stable until ACK. Deassert REQ, or present a new transaction, the cycle after ACK.
- Throughput: one requester alone is acked every cycle. Two continuous requesters are acked alternately A, B, A, B, ...
- CLR_START in IDLE: the next state is CLEAR and no ACK is issued that cycle. CLR_START has priority over pending REQs.
- CLEAR state:
  - RF_WR = 1, RF_DIN = 0, RF_ADRX = counter, RF_ADRY = 0.
  - The counter increments 0 to 31, one register per cycle.
  - CLR_BUSY = 1; A_ACK = B_ACK = 0; REQs stay pending.
- Leaving CLEAR: in the cycle where counter = 31, at the edge the counter wraps to 0 and the state returns to IDLE. CLR_DONE = 1 for the first IDLE cycle. Requests may be acked in that same cycle.
- Clear duration: 32 cycles with CLR_BUSY high.
- CLR_START is ignored while in CLEAR.
- RST asserted mid-CLEAR aborts the clear on the next edge with no CLR_DONE. Registers already written stay 0.
- RST has priority over everything. No ACK is issued in a cycle where RST = 1.
- All read-data registers are cleared only by RST, not by a clear sequence.

Optional Feature:
Macro: RF_ARB_LOCK_EN.
- Defined:
  - Adds input ports A_LOCK and B_LOCK (1 bit each).
  - If last_grant's requester asserts REQ and LOCK, it wins even when the other requester is requesting. This gives back-to-back acks for atomic read-modify-write.
  - LOCK without REQ has no effect.
  - CLEAR still has priority over a lock.
- Not defined: no LOCK ports; pure round-robin as specified above.

Test Plan:
- Reset, then A: REQ with WE=1, ADRX=3, DIN=0x5A; then REQ with WE=0, ADRX=3, ADRY=3 -> A_ACK both cycles; A_DX = A_DY = 0x5A one cycle after the second ACK.
- A and B both REQ read continuously from reset -> ACK order A, B, A, B; RF_ADRX follows the winner each cycle.
- B writes reg 7 = 0xFF while A is idle -> B_ACK every cycle; A_ACK never asserted; RF_WR = 1 only in B ACK cycles.
- Fill regs 0..31 with 0xA5, pulse CLR_START with A_REQ held -> CLR_BUSY high 32 cycles; no ACK; CLR_DONE pulses; A acked in the CLR_DONE cycle; all regs read 0x00.
- RST pulsed at clear counter 10 -> IDLE next cycle; no CLR_DONE; regs 0..9 = 0, regs 10..31 still 0xA5.
- With RF_ARB_LOCK_EN: A holds REQ+LOCK, B holds REQ -> A acked 4 consecutive cycles; A drops LOCK -> B acked next.
